// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write engine.
// Contents:
//   state_t        FSM state encoding
//   LCD_INIT_*     HD44780 init command bytes, in the order they are issued
//   LCD_CMD_*      DDRAM address command base and the row-1 offset
//   lcd_req_t      layout of one buffered write request {pos, chr}
//   init_byte()    returns init command number idx
//   ddram_addr()   builds the set-DDRAM-address command for a row/column position
package lcd_pkg;

    typedef enum logic [3:0] {
        S_PWRUP       = 4'd0,
        S_INIT_SETUP  = 4'd1,
        S_INIT_PULSE  = 4'd2,
        S_INIT_SETTLE = 4'd3,
        S_IDLE        = 4'd4,
        S_ADDR_SETUP  = 4'd5,
        S_ADDR_PULSE  = 4'd6,
        S_ADDR_SETTLE = 4'd7,
        S_DATA_SETUP  = 4'd8,
        S_DATA_PULSE  = 4'd9,
        S_DATA_SETTLE = 4'd10
    } state_t;

    localparam logic [7:0] LCD_INIT_FUNC  = 8'h38;  // 8-bit bus, 2 lines
    localparam logic [7:0] LCD_INIT_DISP  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_INIT_ENTRY = 8'h06;  // increment, no shift
    localparam logic [7:0] LCD_INIT_CLEAR = 8'h01;  // clear display (long settle)

    localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] LCD_ROW1_OFF      = 8'h40;

    localparam int unsigned REQ_W = 13;

    typedef struct packed {
        logic [4:0] pos;
        logic [7:0] chr;
    } lcd_req_t;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = LCD_INIT_FUNC;
            2'd1:    b = LCD_INIT_DISP;
            2'd2:    b = LCD_INIT_ENTRY;
            default: b = LCD_INIT_CLEAR;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] ddram_addr(input logic [4:0] pos);
        return LCD_CMD_SET_DDRAM | (pos[4] ? LCD_ROW1_OFF : 8'h00) | {4'h0, pos[3:0]};
    endfunction

endpackage

// File: rtl/lcd_req_fifo.sv
// Request FIFO for the LCD write engine.
// Ports:
//   clk_sys  in   clock, all state on rising edge
//   rst_b    in   asynchronous active-low reset; empties the FIFO
//   push     in   write wdata (ignored while full)
//   pop      in   advance the read pointer (ignored while empty)
//   wdata    in   entry to store
//   rdata    out  head entry, valid while !empty
//   count    out  registered occupancy
//   full     out  count == DEPTH
//   empty    out  count == 0
module lcd_req_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_sys,
    input  logic                       rst_b,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/lcd_write_engine.sv
// HD44780 write engine for the DE2 16x2 LCD.
// Buffers (position, character) requests, runs the power-up/init sequence, then
// replays each request as a set-DDRAM-address command followed by a data write.
// Ports:
//   CLOCK_50   in   system clock
//   reset      in   asynchronous active-low reset
//   wr_valid   in   request strobe, taken when wr_valid & wr_ready
//   wr_pos     in   [4] row, [3:0] column
//   wr_char    in   character code
//   wr_ready   out  request FIFO not full
//   init_done  out  init sequence finished (sticky until reset)
//   busy       out  FSM not idle or requests pending
//   LCD_ON, LCD_BLON, LCD_RW   constant pad levels
//   LCD_EN, LCD_RS, LCD_DATA   registered LCD bus
//
// state          | meaning
// ---------------+--------------------------------------------------------
// S_PWRUP        | post-reset wait, EN low
// S_INIT_SETUP   | init byte on DATA, RS=0, EN low
// S_INIT_PULSE   | EN high
// S_INIT_SETTLE  | EN low; clear uses the long settle, others the short one
// S_IDLE         | waiting for a request; pops the head when one is present
// S_ADDR_SETUP   | DDRAM address on DATA, RS=0, EN low
// S_ADDR_PULSE   | EN high
// S_ADDR_SETTLE  | EN low, command settle
// S_DATA_SETUP   | character on DATA, RS=1, EN low
// S_DATA_PULSE   | EN high
// S_DATA_SETTLE  | EN low, command settle, then back to idle
module lcd_write_engine
    import lcd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PWRUP_CYC  = 750000,
    parameter int unsigned EN_CYC     = 16,
    parameter int unsigned SETUP_CYC  = 4,
    parameter int unsigned CMD_CYC    = 2000,
    parameter int unsigned CLEAR_CYC  = 82000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       wr_valid,
    input  logic [4:0] wr_pos,
    input  logic [7:0] wr_char,
    output logic       wr_ready,
    output logic       init_done,
    output logic       busy,
    output logic       LCD_ON,
    output logic       LCD_BLON,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic [7:0] LCD_DATA
);

    localparam int unsigned CNT_MAX = (PWRUP_CYC > CLEAR_CYC) ? PWRUP_CYC : CLEAR_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH + 1);

    // Counter runs up from zero after every state change; each phase ends on N-1.
    localparam logic [CNT_W-1:0] T_PWRUP = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] T_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] T_EN    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] T_CMD   = CNT_W'(CMD_CYC - 1);
    localparam logic [CNT_W-1:0] T_CLEAR = CNT_W'(CLEAR_CYC - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        init_idx;
    logic [1:0]        init_idx_nxt;
    logic [7:0]        char_q;
    logic [7:0]        char_nxt;
    logic              en_q;
    logic              en_nxt;
    logic              rs_q;
    logic              rs_nxt;
    logic [7:0]        data_q;
    logic [7:0]        data_nxt;
    logic              init_done_q;
    logic              init_done_nxt;
    logic              pop;
    logic [CNT_W-1:0]  init_settle_t;

    logic [REQ_W-1:0]  head_bits;
    lcd_req_t          head;
    logic [FCNT_W-1:0] fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    lcd_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (CLOCK_50),
        .rst_b   (reset),
        .push    (wr_valid),
        .pop     (pop),
        .wdata   ({wr_pos, wr_char}),
        .rdata   (head_bits),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head          = lcd_req_t'(head_bits);
    assign init_settle_t = (init_idx == 2'd3) ? T_CLEAR : T_CMD;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state       <= S_PWRUP;
            cnt         <= '0;
            init_idx    <= 2'd0;
            char_q      <= 8'h00;
            en_q        <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            init_done_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            init_idx    <= init_idx_nxt;
            char_q      <= char_nxt;
            en_q        <= en_nxt;
            rs_q        <= rs_nxt;
            data_q      <= data_nxt;
            init_done_q <= init_done_nxt;
            // Held at zero in IDLE so an arbitrarily long idle never wraps it.
            if (state_nxt != state || state == S_IDLE) cnt <= '0;
            else                                       cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        init_idx_nxt  = init_idx;
        char_nxt      = char_q;
        en_nxt        = en_q;
        rs_nxt        = rs_q;
        data_nxt      = data_q;
        init_done_nxt = init_done_q;
        pop           = 1'b0;

        case (state)
            S_PWRUP: begin
                if (cnt == T_PWRUP) begin
                    state_nxt = S_INIT_SETUP;
                    rs_nxt    = 1'b0;
                    data_nxt  = init_byte(init_idx);
                end
            end
            S_INIT_SETUP: begin
                if (cnt == T_SETUP) begin
                    state_nxt = S_INIT_PULSE;
                    en_nxt    = 1'b1;
                end
            end
            S_INIT_PULSE: begin
                if (cnt == T_EN) begin
                    state_nxt = S_INIT_SETTLE;
                    en_nxt    = 1'b0;
                end
            end
            S_INIT_SETTLE: begin
                if (cnt == init_settle_t) begin
                    if (init_idx == 2'd3) begin
                        state_nxt     = S_IDLE;
                        init_done_nxt = 1'b1;
                    end else begin
                        state_nxt    = S_INIT_SETUP;
                        init_idx_nxt = init_idx + 2'd1;
                        data_nxt     = init_byte(init_idx + 2'd1);
                    end
                end
            end
            S_IDLE: begin
                if (init_done_q && !fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = S_ADDR_SETUP;
                    rs_nxt    = 1'b0;
                    data_nxt  = ddram_addr(head.pos);
                    char_nxt  = head.chr;
                end
            end
            S_ADDR_SETUP: begin
                if (cnt == T_SETUP) begin
                    state_nxt = S_ADDR_PULSE;
                    en_nxt    = 1'b1;
                end
            end
            S_ADDR_PULSE: begin
                if (cnt == T_EN) begin
                    state_nxt = S_ADDR_SETTLE;
                    en_nxt    = 1'b0;
                end
            end
            S_ADDR_SETTLE: begin
                if (cnt == T_CMD) begin
                    state_nxt = S_DATA_SETUP;
                    rs_nxt    = 1'b1;
                    data_nxt  = char_q;
                end
            end
            S_DATA_SETUP: begin
                if (cnt == T_SETUP) begin
                    state_nxt = S_DATA_PULSE;
                    en_nxt    = 1'b1;
                end
            end
            S_DATA_PULSE: begin
                if (cnt == T_EN) begin
                    state_nxt = S_DATA_SETTLE;
                    en_nxt    = 1'b0;
                end
            end
            S_DATA_SETTLE: begin
                if (cnt == T_CMD) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_PWRUP;
                en_nxt    = 1'b0;
            end
        endcase
    end

    assign wr_ready  = ~fifo_full;
    assign init_done = init_done_q;
    assign busy      = (state != S_IDLE) || (fifo_count != '0);
    assign LCD_ON    = 1'b1;
    assign LCD_BLON  = 1'b1;
    assign LCD_RW    = 1'b0;
    assign LCD_EN    = en_q;
    assign LCD_RS    = rs_q;
    assign LCD_DATA  = data_q;

endmodule

// File: tb/tb_lcd_write_engine.sv
module tb_lcd_write_engine;

    localparam int PWRUP = 20;
    localparam int SETUP = 2;
    localparam int ENC   = 3;
    localparam int CMD   = 5;
    localparam int CLEAR = 10;
    localparam int XFER  = SETUP + ENC + CMD;                      // rise-to-rise within a pair
    localparam int INIT_DONE_CYC = PWRUP + 4*(SETUP + ENC) + 3*CMD + CLEAR;  // 65

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_valid = 1'b0;
    logic [4:0] wr_pos = 5'h00;
    logic [7:0] wr_char = 8'h00;
    logic       wr_ready, init_done, busy;
    logic       lcd_on, lcd_blon, lcd_rw, lcd_en, lcd_rs;
    logic [7:0] lcd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [8:0] exp_q[$];     // {rs, data} per expected EN pulse
    int         rise_cyc[$];
    int         last_fall = 0;

    lcd_write_engine #(
        .FIFO_DEPTH (4),
        .PWRUP_CYC  (PWRUP),
        .EN_CYC     (ENC),
        .SETUP_CYC  (SETUP),
        .CMD_CYC    (CMD),
        .CLEAR_CYC  (CLEAR)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_pos    (wr_pos),
        .wr_char   (wr_char),
        .wr_ready  (wr_ready),
        .init_done (init_done),
        .busy      (busy),
        .LCD_ON    (lcd_on),
        .LCD_BLON  (lcd_blon),
        .LCD_RW    (lcd_rw),
        .LCD_EN    (lcd_en),
        .LCD_RS    (lcd_rs),
        .LCD_DATA  (lcd_data)
    );

    always #5 clk = ~clk;

    // Edge number since reset release: the first rising edge after release is 1.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [7:0] addr_of(input logic [4:0] p);
        return (p[4] ? 8'hC0 : 8'h80) + {4'h0, p[3:0]};
    endfunction

    // Monitor: every EN rise is matched against the scoreboard; each pulse is
    // checked for width and for RS/DATA stability while EN is high.
    initial begin : monitor
        logic       en_prev;
        logic       p_rs;
        logic [7:0] p_data;
        int         p_len;
        logic       unstable;
        logic [8:0] e;
        en_prev = 1'b0; p_rs = 1'b0; p_data = 8'h00; p_len = 0; unstable = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                en_prev = 1'b0;
            end else begin
                if (lcd_en && !en_prev) begin
                    rise_cyc.push_back(cyc);
                    p_rs = lcd_rs; p_data = lcd_data; p_len = 1; unstable = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_pulse: got rs=%0b data=0x%0h, expected no pulse (cycle %0d)",
                                 lcd_rs, lcd_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("xfer_rs_data", {23'd0, lcd_rs, lcd_data}, {23'd0, e});
                    end
                end else if (lcd_en && en_prev) begin
                    p_len++;
                    if (lcd_rs !== p_rs || lcd_data !== p_data) unstable = 1'b1;
                end else if (!lcd_en && en_prev) begin
                    last_fall = cyc;
                    check("en_width", p_len, ENC);
                    check("stable_while_en", {31'd0, unstable}, 32'd0);
                end
                en_prev = lcd_en;
            end
        end
    end

    task automatic push_req(input logic [4:0] pos, input logic [7:0] ch, output bit acc);
        @(negedge clk);
        wr_valid = 1'b1; wr_pos = pos; wr_char = ch;
        acc = wr_ready;
        if (acc) begin
            exp_q.push_back({1'b0, addr_of(pos)});
            exp_q.push_back({1'b1, ch});
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete(); rise_cyc.delete();
        check("rst_en", {31'd0, lcd_en}, 0);
        check("rst_rs", {31'd0, lcd_rs}, 0);
        check("rst_data", {24'd0, lcd_data}, 0);
        check("rst_init_done", {31'd0, init_done}, 0);
        check("rst_busy", {31'd0, busy}, 1);
        check("rst_wr_ready", {31'd0, wr_ready}, 1);
        reset = 1'b1;
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    task automatic wait_init(input int budget, output int at, output logic busy_at);
        at = -1; busy_at = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (init_done) begin at = cyc; busy_at = busy; break; end
        end
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && !lcd_en && exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        check("idle_reached", {31'd0, ok}, 1);
    endtask

    initial begin : stim
        int   at;
        logic b;
        bit   acc;
        int   base;

        // 1: init sequence with no requests
        do_reset();
        check("const_on", {31'd0, lcd_on}, 1);
        check("const_blon", {31'd0, lcd_blon}, 1);
        check("const_rw", {31'd0, lcd_rw}, 0);
        wait_init(200, at, b);
        check("init_done_cycle", at, INIT_DONE_CYC);
        check("busy_after_init", {31'd0, b}, 0);
        check("init_pulse_count", rise_cyc.size(), 4);
        if (rise_cyc.size() == 4) begin
            check("first_en_rise", rise_cyc[0], PWRUP + SETUP);
            check("init_rise_gap", rise_cyc[3] - rise_cyc[2], XFER);
        end

        // 2: single request, row 1 col 3
        base = rise_cyc.size();
        push_req(5'h13, 8'h41, acc);
        check("t2_accept", {31'd0, acc}, 1);
        wait_idle(100);
        check("t2_pulse_count", rise_cyc.size(), base + 2);
        if (rise_cyc.size() == base + 2)
            check("t2_addr_data_gap", rise_cyc[base+1] - rise_cyc[base], XFER);
        check("t2_busy", {31'd0, busy}, 0);

        // 3: fill FIFO during power-up
        do_reset();
        push_req(5'h00, 8'h41, acc);
        push_req(5'h05, 8'h42, acc);
        push_req(5'h1F, 8'h43, acc);
        push_req(5'h0F, 8'h44, acc);
        check("t3_full_wr_ready", {31'd0, wr_ready}, 0);
        push_req(5'h10, 8'h5A, acc);
        check("t3_fifth_ignored", {31'd0, acc}, 0);
        wait_init(200, at, b);
        check("t3_init_done_cycle", at, INIT_DONE_CYC);
        wait_idle(300);
        check("t3_pulse_count", rise_cyc.size(), 12);
        if (rise_cyc.size() == 12)
            check("t3_char_period", rise_cyc[6] - rise_cyc[4], 2*XFER + 1);

        // 4: wr_valid held high against a full FIFO
        begin
            int   i;
            logic prev_rdy, rdy;
            bit   saw_full, checked;
            i = 0; prev_rdy = 1'b1; saw_full = 1'b0; checked = 1'b0;
            base = rise_cyc.size();
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (i == 6) break;
                rdy = wr_ready;
                if (!rdy) saw_full = 1'b1;
                if (!prev_rdy && rdy && !checked) begin
                    check("t4_ready_after_pop", cyc, last_fall + CMD + 1);
                    checked = 1'b1;
                end
                wr_valid = 1'b1;
                wr_pos   = {i[0], 4'(i + 2)};
                wr_char  = 8'h60 + 8'(i);
                if (rdy) begin
                    exp_q.push_back({1'b0, addr_of(wr_pos)});
                    exp_q.push_back({1'b1, wr_char});
                    i++;
                end
                prev_rdy = rdy;
            end
            wr_valid = 1'b0;
            check("t4_all_accepted", i, 6);
            check("t4_saw_full", {31'd0, saw_full}, 1);
            check("t4_ready_check_hit", {31'd0, checked}, 1);
            wait_idle(400);
            check("t4_pulse_count", rise_cyc.size(), base + 12);
        end

        // 6: row boundary addresses
        push_req(5'h0F, 8'h78, acc);
        push_req(5'h10, 8'h79, acc);
        wait_idle(200);

        // 5: reset during the EN pulse of a data transfer
        push_req(5'h02, 8'h30, acc);
        push_req(5'h12, 8'h31, acc);
        begin
            bit hit;
            hit = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (lcd_en && lcd_rs) begin hit = 1'b1; break; end
            end
            check("t5_data_pulse_seen", {31'd0, hit}, 1);
        end
        #2 reset = 1'b0;
        #1;
        check("t5_async_en", {31'd0, lcd_en}, 0);
        check("t5_init_done_clr", {31'd0, init_done}, 0);
        check("t5_wr_ready", {31'd0, wr_ready}, 1);
        check("t5_busy", {31'd0, busy}, 1);
        do_reset();
        wait_init(200, at, b);
        check("t5_init_done_cycle", at, INIT_DONE_CYC);
        repeat (30) @(negedge clk);
        check("t5_no_replay", rise_cyc.size(), 4);
        check("t5_busy_end", {31'd0, busy}, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
